// File: rtl/axis_join_ctrl_if.sv
// Handshake bundle for the four-channel beam-sum join controller.
// Carries the per-channel valid/last/ready and the single joined
// valid/last/ready pair toward the adder.
//   slave  : the join controller (consumes channel valid/last, drives readies)
//   master : the surrounding stream sources and adder
interface axis_join_ctrl_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] s_tvalid;
  logic [N_CH-1:0] s_tlast;
  logic [N_CH-1:0] s_tready;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;

  modport slave (
    input  s_tvalid,
    input  s_tlast,
    input  m_tready,
    output s_tready,
    output m_tvalid,
    output m_tlast
  );

  modport master (
    output s_tvalid,
    output s_tlast,
    output m_tready,
    input  s_tready,
    input  m_tvalid,
    input  m_tlast
  );
endinterface

// File: rtl/axis_join_ctrl.sv
// Frame-aligning join controller for the four-channel beam-sum adder.
// Drains every channel to a frame boundary (FLUSH) before joining, then
// consumes one beat from all channels at once (RUN) only when every channel
// has a beat and the adder is ready. A beat whose tlast bits disagree across
// channels is a framing error: it is counted, pulsed on sync_lost, and the
// controller re-flushes so sums always come from time-aligned frames.
//
// Optional feature macro: AXIS_JOIN_LEN_CHECK_EN
//   When defined, a coherent tlast that arrives at any beat other than
//   FRAME_LEN-1, or a missing tlast at beat FRAME_LEN-1, is also a framing
//   error. When undefined, only tlast coherence is checked and beat_cnt
//   wraps naturally.
module axis_join_ctrl #(
  parameter int N_CH      = 4,
  parameter int FRAME_LEN = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  axis_join_ctrl_if.slave      bus,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 sync_lost
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // A frame shorter than two beats cannot distinguish first from last beat.
  if (FRAME_LEN < 2) begin : g_frame_len_bad
    $error("axis_join_ctrl: FRAME_LEN must be at least 2");
  end

  // Saturating increment for the framing-error counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [N_CH-1:0]      parked_r, parked_nxt_s;
  logic [CNT_WIDTH-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic [CNT_WIDTH-1:0] err_cnt_r, err_cnt_nxt_s;
  logic                 sync_lost_r, sync_lost_nxt_s;
  logic                 stop_pending_r, stop_pending_nxt_s;

  logic [N_CH-1:0]      s_tready_s;
  logic                 m_tvalid_s;
  logic                 m_tlast_s;
  logic                 fire_s;
  logic                 all_last_s;
  logic                 no_last_s;
  logic                 len_err_s;
  logic                 frame_err_s;

  // Handshake outputs: combinational from registered state and live inputs.
  always_comb begin
    s_tready_s = {N_CH{1'b0}};
    m_tvalid_s = 1'b0;
    m_tlast_s  = 1'b0;
    fire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_tready_s = {N_CH{1'b0}};
      end
      ST_FLUSH: begin
        // Unparked channels are drained; parked ones wait at the boundary.
        s_tready_s = ~parked_r;
      end
      ST_RUN: begin
        // All-or-none consumption keeps channels beat-aligned.
        m_tvalid_s = &bus.s_tvalid;
        m_tlast_s  = bus.s_tlast[0];
        fire_s     = m_tvalid_s & bus.m_tready;
        s_tready_s = {N_CH{fire_s}};
      end
      default: begin
        s_tready_s = {N_CH{1'b0}};
      end
    endcase
  end

  // Framing-error decode for the beat being joined this cycle.
  always_comb begin
    all_last_s = &bus.s_tlast;
    no_last_s  = ~|bus.s_tlast;
`ifdef AXIS_JOIN_LEN_CHECK_EN
    if (beat_cnt_r == CNT_WIDTH'(FRAME_LEN - 1)) begin
      len_err_s = no_last_s;
    end else begin
      len_err_s = all_last_s;
    end
`else
    len_err_s = 1'b0;
`endif
    frame_err_s = fire_s & (~(all_last_s | no_last_s) | len_err_s);
  end

  // Next-state and counter update logic for the IDLE/FLUSH/RUN controller.
  always_comb begin
    state_nxt_s        = state_r;
    parked_nxt_s       = parked_r;
    beat_cnt_nxt_s     = beat_cnt_r;
    err_cnt_nxt_s      = err_cnt_r;
    sync_lost_nxt_s    = 1'b0;
    stop_pending_nxt_s = stop_pending_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt_s  = ST_FLUSH;
          parked_nxt_s = {N_CH{1'b0}};
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (!enable) begin
          state_nxt_s        = ST_IDLE;
          parked_nxt_s       = {N_CH{1'b0}};
          stop_pending_nxt_s = 1'b0;
        end else if (&parked_r) begin
          // Every channel sits at a frame boundary: start joining.
          state_nxt_s        = ST_RUN;
          parked_nxt_s       = {N_CH{1'b0}};
          beat_cnt_nxt_s     = CNT_ZERO;
          stop_pending_nxt_s = 1'b0;
        end else begin
          parked_nxt_s = parked_r | (bus.s_tvalid & s_tready_s & bus.s_tlast);
        end
      end
      ST_RUN: begin
        if (frame_err_s) begin
          // Error outranks a pending stop; channels that just saw tlast
          // are already at their boundary.
          state_nxt_s        = ST_FLUSH;
          parked_nxt_s       = bus.s_tlast;
          beat_cnt_nxt_s     = CNT_ZERO;
          err_cnt_nxt_s      = sat_inc(err_cnt_r);
          sync_lost_nxt_s    = 1'b1;
          stop_pending_nxt_s = 1'b0;
        end else if (fire_s) begin
          if (all_last_s) begin
            beat_cnt_nxt_s = CNT_ZERO;
            if (stop_pending_r || !enable) begin
              state_nxt_s        = ST_IDLE;
              stop_pending_nxt_s = 1'b0;
            end else begin
              state_nxt_s        = ST_RUN;
            end
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
            if (!enable) begin
              stop_pending_nxt_s = 1'b1;
            end else begin
              stop_pending_nxt_s = stop_pending_r;
            end
          end
        end else begin
          if (!enable && (beat_cnt_r == CNT_ZERO)) begin
            state_nxt_s        = ST_IDLE;
            stop_pending_nxt_s = 1'b0;
          end else if (!enable) begin
            stop_pending_nxt_s = 1'b1;
          end else begin
            stop_pending_nxt_s = stop_pending_r;
          end
        end
      end
      default: begin
        state_nxt_s        = ST_IDLE;
        parked_nxt_s       = {N_CH{1'b0}};
        beat_cnt_nxt_s     = CNT_ZERO;
        stop_pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset abandons any partial frame at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      parked_r       <= {N_CH{1'b0}};
      beat_cnt_r     <= CNT_ZERO;
      err_cnt_r      <= CNT_ZERO;
      sync_lost_r    <= 1'b0;
      stop_pending_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      parked_r       <= parked_nxt_s;
      beat_cnt_r     <= beat_cnt_nxt_s;
      err_cnt_r      <= err_cnt_nxt_s;
      sync_lost_r    <= sync_lost_nxt_s;
      stop_pending_r <= stop_pending_nxt_s;
    end
  end

  assign bus.s_tready = s_tready_s;
  assign bus.m_tvalid = m_tvalid_s;
  assign bus.m_tlast  = m_tlast_s;
  assign state        = state_r;
  assign beat_cnt     = beat_cnt_r;
  assign err_cnt      = err_cnt_r;
  assign sync_lost    = sync_lost_r;

endmodule
